// File: rtl/storage_pkg.sv
// Shared definitions for the per-core storage read client, the port arbiter
// and the storage side: issue states, default field widths, field helpers.
package storage_pkg;

  localparam int ID_W_DEF   = 4;
  localparam int TAG_W_DEF  = 2;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef logic [1:0] issue_state_t;

  localparam issue_state_t ST_IDLE = 2'd0;
  localparam issue_state_t ST_REQ  = 2'd1;
  localparam issue_state_t ST_SEND = 2'd2;

  localparam int REQ_W_DEF = ID_W_DEF + TAG_W_DEF + ADDR_W_DEF;
  localparam int RSP_W_DEF = ID_W_DEF + TAG_W_DEF + DATA_W_DEF;

  // Field helpers for the default-width request/response words.
  function automatic logic [REQ_W_DEF-1:0] pack_req(
    input logic [ID_W_DEF-1:0]   id,
    input logic [TAG_W_DEF-1:0]  tag,
    input logic [ADDR_W_DEF-1:0] addr
  );
    return {id, tag, addr};
  endfunction

  function automatic logic [ID_W_DEF-1:0] resp_id(input logic [RSP_W_DEF-1:0] rsp);
    return rsp[RSP_W_DEF-1 -: ID_W_DEF];
  endfunction

  function automatic logic [TAG_W_DEF-1:0] resp_tag(input logic [RSP_W_DEF-1:0] rsp);
    return rsp[DATA_W_DEF +: TAG_W_DEF];
  endfunction

  function automatic logic [DATA_W_DEF-1:0] resp_data(input logic [RSP_W_DEF-1:0] rsp);
    return rsp[DATA_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/storage_tag_tracker.sv
// Outstanding-read tracker: in-order tag window, per-head timeout, and the
// match / mismatch / timeout decision for each incoming response.
module storage_tag_tracker
  import storage_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             rsp_valid_i,
  input  logic [TAG_W-1:0] rsp_tag_i,
  output logic             has_room_o,
  output logic [TAG_W-1:0] next_tag_o,
  output logic             hit_o,
  output logic             err_o,
  output logic             timeout_o
);

  localparam int                 DEPTH    = 1 << TAG_W;
  localparam int                 CNT_W    = TAG_W + 1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
  localparam logic [TAG_W-1:0]   TAG_ONE  = TAG_W'(1);
  localparam logic [15:0]        TMO_LAST = 16'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] next_q, next_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             busy_s, pop_s;

  assign busy_s     = (count_q != {CNT_W{1'b0}});
  assign hit_o      = rsp_valid_i && busy_s && (rsp_tag_i == head_q);
  // The age counter includes the issue cycle, so the head is abandoned
  // TIMEOUT cycles after it was sent; a matching response that cycle wins.
  assign timeout_o  = busy_s && (tmo_q >= TMO_LAST) && !hit_o;
  assign err_o      = (rsp_valid_i && !hit_o) || timeout_o;
  assign pop_s      = hit_o || timeout_o;
  assign has_room_o = (count_q < CNT_FULL);
  assign next_tag_o = next_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    next_d  = next_q;
    tmo_d   = 16'd0;
    case ({push_i, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push_i) begin
      next_d = next_q + TAG_ONE;
    end else begin
      next_d = next_q;
    end
    if (pop_s) begin
      head_d = head_q + TAG_ONE;
    end else begin
      head_d = head_q;
    end
    if (pop_s) begin
      tmo_d = 16'd0;
    end else if (busy_s || push_i) begin
      tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      head_q  <= {TAG_W{1'b0}};
      next_q  <= {TAG_W{1'b0}};
      tmo_q   <= 16'd0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      next_q  <= next_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: rtl/storage_client.sv
// Per-core read client: arbitrates for the shared storage port, issues tagged
// reads and reports in-order completions, mismatches and timeouts to the core.
module storage_client
  import storage_pkg::*;
#(
  parameter int CORE_ID   = 1,
  parameter int GRANT_IDX = 0,
  parameter int N_CORES   = 4,
  parameter int ID_W      = ID_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_ce,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_ready,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_done,
  output logic                         rd_err,
  output logic                         req,
  input  logic [N_CORES-1:0]           grant,
  output logic [ID_W+TAG_W+ADDR_W-1:0] number_and_addr,
  output logic                         storage_valid,
  input  logic                         txn_done,
  input  logic [ID_W+TAG_W+DATA_W-1:0] data_from_storage
);

  localparam int              NA_W  = ID_W + TAG_W + ADDR_W;
  localparam int              RSP_W = ID_W + TAG_W + DATA_W;
  localparam logic [ID_W-1:0] MY_ID = ID_W'(CORE_ID);

  issue_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NA_W-1:0]   nad_q, nad_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_err_q, rd_err_d;

  logic [ID_W-1:0]   rsp_id_s;
  logic [TAG_W-1:0]  rsp_tag_s;
  logic [DATA_W-1:0] rsp_data_s;
  logic [TAG_W-1:0]  next_tag_s;
  logic              rsp_mine_s, push_s, has_room_s, ready_s;
  logic              hit_s, err_s, tmo_s;

  assign rsp_id_s   = data_from_storage[RSP_W-1 -: ID_W];
  assign rsp_tag_s  = data_from_storage[DATA_W +: TAG_W];
  assign rsp_data_s = data_from_storage[DATA_W-1:0];
  assign rsp_mine_s = txn_done && (rsp_id_s == MY_ID);
  assign push_s     = (state_q == ST_SEND);
  assign ready_s    = (state_q == ST_IDLE) && has_room_s;

  storage_tag_tracker #(
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .rsp_valid_i (rsp_mine_s),
    .rsp_tag_i   (rsp_tag_s),
    .has_room_o  (has_room_s),
    .next_tag_o  (next_tag_s),
    .hit_o       (hit_s),
    .err_o       (err_s),
    .timeout_o   (tmo_s)
  );

  // next_tag only moves in SEND, so capturing it on the grant is stable.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    nad_d   = nad_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_ce && ready_s) begin
          addr_d  = rd_addr;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (grant[GRANT_IDX]) begin
          nad_d   = {MY_ID, next_tag_s, addr_q};
          state_d = ST_SEND;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SEND: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_done_d = hit_s;
    rd_err_d  = err_s;
    if (hit_s) begin
      rd_data_d = rsp_data_s;
    end else if (tmo_s) begin
      rd_data_d = {DATA_W{1'b0}};
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      nad_q     <= {NA_W{1'b0}};
      rd_data_q <= {DATA_W{1'b0}};
      rd_done_q <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      nad_q     <= nad_d;
      rd_data_q <= rd_data_d;
      rd_done_q <= rd_done_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign rd_ready        = ready_s;
  assign req             = (state_q == ST_REQ);
  assign storage_valid   = (state_q == ST_SEND);
  assign number_and_addr = nad_q;
  assign rd_data         = rd_data_q;
  assign rd_done         = rd_done_q;
  assign rd_err          = rd_err_q;

endmodule
